// File: rtl/mem_arbiter.sv
// Two-port arbiter for the unified memory port: core (port 0) vs loader/debug (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin contention; fixed port-0 priority otherwise.
module mem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_we
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] burst_cnt;
    logic [3:0] burst_cnt_nxt;
    logic       burst_full;

`ifdef ARB_ROUND_ROBIN_EN
    logic       rr_last;   // 1 = port 1 was granted most recently
`endif

    // >= rather than == so an owner that ran past the limit uncontended still yields
    assign burst_full = (burst_cnt >= BURST_LIM);

    always_comb begin
        state_nxt = IDLE;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            state_nxt = rr_last ? ACC0 : ACC1;
`else
            state_nxt = ACC0;
`endif
            if ((state == ACC0) && lock0) state_nxt = ACC0;
            if ((state == ACC1) && lock1) state_nxt = ACC1;
            if ((state_nxt == state) && burst_full)
                state_nxt = (state == ACC0) ? ACC1 : ACC0;
        end else if (req0) begin
            state_nxt = ACC0;
        end else if (req1) begin
            state_nxt = ACC1;
        end
    end

    always_comb begin
        burst_cnt_nxt = '0;
        if ((state_nxt != IDLE) && (state_nxt == state))
            burst_cnt_nxt = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last <= 1'b1;
        end else if (state_nxt == ACC0) begin
            rr_last <= 1'b0;
        end else if (state_nxt == ACC1) begin
            rr_last <= 1'b1;
        end
    end
`endif

    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        case (state)
            ACC0: begin
                gnt0        = 1'b1;
                mem_address = addr0;
                mem_wdata   = wdata0;
                mem_we      = we0;
            end
            ACC1: begin
                gnt1        = 1'b1;
                mem_address = addr1;
                mem_wdata   = wdata1;
                mem_we      = we1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= (state == ACC0) && !we0;
            rvalid1 <= (state == ACC1) && !we1;
            if (((state == ACC0) && !we0) || ((state == ACC1) && !we1))
                rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a small behavioural memory attached.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata, mem_address, mem_wdata, mem_rdata;

    logic [31:0] mem [0:2047];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_we(mem_we)
    );

    always @(posedge clk) if (mem_we) mem[mem_address[12:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_address[12:2]];

    typedef struct {
        logic        r0, l0, w0;
        logic [31:0] a0, d0;
        logic        r1, l1, w1;
        logic [31:0] a1, d1;
        logic        eg0, eg1, ev0, ev1, emwe;
        logic [31:0] emaddr, erdata;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input logic r0, l0, w0, input logic [31:0] a0, d0,
                        input logic r1, l1, w1, input logic [31:0] a1, d1,
                        input logic eg0, eg1, ev0, ev1, emwe,
                        input logic [31:0] emaddr, erdata);
        vec_t v;
        v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1; v.emwe = emwe;
        v.emaddr = emaddr; v.erdata = erdata;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Owner sequence for a pattern row: 0 = port 0, 1 = port 1
    function automatic int cont_owner(input int k);
`ifdef ARB_ROUND_ROBIN_EN
        return k % 2;
`else
        return (k % 5 == 4) ? 1 : 0;
`endif
    endfunction

    function automatic int lock_owner(input int j);
        return (j == 4) ? 1 : 0;
    endfunction

    initial begin
        logic [31:0] rd;
        int          prev;
        int          o;
        logic        hold;

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[0]     = 32'h0050_0093;
        mem[1]     = 32'h1111_1111;
        mem[2]     = 32'h2222_2222;
        mem[10'h201] = 32'h3333_3333;

        // Rows: r0 l0 w0 a0 d0 | r1 l1 w1 a1 d1 | gnt0 gnt1 rv0 rv1 mem_we | mem_address rdata
        push(1,0,0,32'h0,'0, 0,0,0,32'h0,'0,         0,0,0,0,0, 32'h0,   32'h0);
        push(0,0,0,32'h0,'0, 0,0,0,32'h0,'0,         1,0,0,0,0, 32'h0,   32'h0);
        push(0,0,0,32'h0,'0, 1,0,1,32'h800,32'hDEADBEEF, 0,0,1,0,0, 32'h0, 32'h0050_0093);
        push(0,0,0,32'h0,'0, 0,0,1,32'h800,32'hDEADBEEF, 0,1,0,0,1, 32'h800, 32'h0050_0093);
        push(0,0,0,32'h0,'0, 1,0,0,32'h800,'0,       0,0,0,0,0, 32'h0,   32'h0050_0093);
        push(0,0,0,32'h0,'0, 0,0,0,32'h800,'0,       0,1,0,0,0, 32'h800, 32'h0050_0093);
        push(0,0,0,32'h0,'0, 0,0,0,32'h0,'0,         0,0,0,1,0, 32'h0,   32'hDEADBEEF);
        push(1,0,0,32'h4,'0, 1,0,0,32'h804,'0,       0,0,0,0,0, 32'h0,   32'hDEADBEEF);

        // Continuous contention, no lock; requests drop in the final row
        rd = 32'hDEADBEEF;
        prev = -1;
        for (int k = 0; k < 10; k++) begin
            o = cont_owner(k);
            hold = (k < 9);
            if (prev == 0) rd = 32'h1111_1111;
            if (prev == 1) rd = 32'h3333_3333;
            push(hold,0,0,32'h4,'0, hold,0,0,32'h804,'0,
                 o == 0, o == 1, prev == 0, prev == 1, 0,
                 (o == 0) ? 32'h4 : 32'h804, rd);
            prev = o;
        end
        push(0,0,0,32'h0,'0, 0,0,0,32'h0,'0,         0,0,0,1,0, 32'h0, 32'h3333_3333);
        push(1,1,0,32'h8,'0, 1,0,0,32'h804,'0,       0,0,0,0,0, 32'h0, 32'h3333_3333);

        // Locked port-0 burst against a continuously requesting port 1
        rd = 32'h3333_3333;
        prev = -1;
        for (int j = 0; j < 8; j++) begin
            o = lock_owner(j);
            hold = (j < 7);
            if (prev == 0) rd = 32'h2222_2222;
            if (prev == 1) rd = 32'h3333_3333;
            push(hold,hold,0,32'h8,'0, hold,0,0,32'h804,'0,
                 o == 0, o == 1, prev == 0, prev == 1, 0,
                 (o == 0) ? 32'h8 : 32'h804, rd);
            prev = o;
        end
        push(0,0,0,32'h0,'0, 0,0,0,32'h0,'0,         0,0,1,0,0, 32'h0, 32'h2222_2222);

        // Single isolated port-1 read, then idle
        push(0,0,0,32'h0,'0, 1,0,0,32'h800,'0,       0,0,0,0,0, 32'h0,   32'h2222_2222);
        push(0,0,0,32'h0,'0, 0,0,0,32'h800,'0,       0,1,0,0,0, 32'h800, 32'h2222_2222);
        push(0,0,0,32'h0,'0, 0,0,0,32'h0,'0,         0,0,0,1,0, 32'h0,   32'hDEADBEEF);
        push(0,0,0,32'h0,'0, 0,0,0,32'h0,'0,         0,0,0,0,0, 32'h0,   32'hDEADBEEF);

        // Reset held with random requests: everything stays quiet
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            we1  = 1'($urandom_range(0, 1));
            addr0 = $urandom; addr1 = $urandom;
            #1;
            chk($sformatf("rst%0d_gnt", c), {30'b0, gnt1, gnt0}, 32'h0);
            chk($sformatf("rst%0d_out", c),
                {28'b0, rvalid1, rvalid0, mem_we, 1'b0} | rdata | mem_address | mem_wdata, 32'h0);
        end
        #1;
        req0 = 0; req1 = 0; we1 = 0; addr0 = '0; addr1 = '0;
        resetn = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            req0 = tbl[i].r0; lock0 = tbl[i].l0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; lock1 = tbl[i].l1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            #1;
            chk($sformatf("row%0d_gnt0", i), {31'b0, gnt0}, {31'b0, tbl[i].eg0});
            chk($sformatf("row%0d_gnt1", i), {31'b0, gnt1}, {31'b0, tbl[i].eg1});
            chk($sformatf("row%0d_rvalid0", i), {31'b0, rvalid0}, {31'b0, tbl[i].ev0});
            chk($sformatf("row%0d_rvalid1", i), {31'b0, rvalid1}, {31'b0, tbl[i].ev1});
            chk($sformatf("row%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].emwe});
            chk($sformatf("row%0d_mem_address", i), mem_address, tbl[i].emaddr);
            chk($sformatf("row%0d_rdata", i), rdata, tbl[i].erdata);
        end
        chk("idle_burst_cnt", {28'b0, dut.burst_cnt}, 32'h0);
        chk("idle_mem_write_kept", mem[10'h200], 32'hDEADBEEF);

        // Reset asserted in the middle of a port-1 write cycle
        @(posedge clk); #1;
        req1 = 1; we1 = 1; addr1 = 32'h808; wdata1 = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req1 = 0;
        #1;
        chk("midrst_pre_mem_we", {31'b0, mem_we}, 32'h1);
        chk("midrst_pre_gnt1", {31'b0, gnt1}, 32'h1);
        chk("midrst_pre_wdata", mem_wdata, 32'hCAFE_F00D);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_mem_we_async", {31'b0, mem_we}, 32'h0);
        chk("midrst_gnt1_async", {31'b0, gnt1}, 32'h0);
        @(posedge clk); #1;
        chk("midrst_rvalid", {30'b0, rvalid1, rvalid0}, 32'h0);
        we1 = 0;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("midrst_post_gnt", {30'b0, gnt1, gnt0}, 32'h0);
        chk("midrst_post_rvalid", {30'b0, rvalid1, rvalid0}, 32'h0);
        chk("midrst_post_rdata", rdata, 32'h0);
        chk("midrst_post_burst_cnt", {28'b0, dut.burst_cnt}, 32'h0);
        chk("midrst_no_write", mem[10'h202], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified memory port (instructions below 0x800, data at 0x800 and above) between the core (port 0) and the memory loader/debug master (port 1). It sits between the requesters and `memory`: it sequences one access per cycle, drives the memory's address, write-data and write-enable, and returns registered read data to the winning requester. It also supports locked bursts with a starvation bound.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MAX_BURST`, 4, maximum consecutive grants to one port while the other port is requesting. Legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  access request. Hold with addr/we/wdata stable until the cycle `gnt` is seen high.
- `lock0`, `lock1`  in  1  request to keep ownership for the next access. Only meaningful while the matching `req` is high.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  AW  byte address.
- `wdata0`, `wdata1`  in  DW  write data.
- `gnt0`, `gnt1`  out  1  high during the cycle the port's access is driven to memory.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse; `rdata` holds the read result. Pulses for reads only.
- `rdata`  out  DW  registered read data, shared by both ports.
- `mem_address`  out  AW  to memory `address`.
- `mem_wdata`  out  DW  to memory `data_in`.
- `mem_rdata`  in  DW  from memory `data_out` (combinational read).
- `mem_we`  out  1  to memory `we`. Memory samples the write on the rising edge.

## Operation
- FSM states:
  - IDLE: no access.
  - ACC0: port 0 owns the memory this cycle.
  - ACC1: port 1 owns the memory this cycle.
- Next state is evaluated at each edge from the sampled `req`/`lock` values:
  - No requests: go to IDLE.
  - One request: go to that port's ACC state.
  - Both requests: go to the winner per the arbitration policy (see Configuration).
  - Lock override: if the current owner holds `req` and `lock`, it keeps ownership unless `burst_cnt == MAX_BURST-1` and the other port is requesting. In that case ownership is forced to the other port.
- The requester that receives a grant must not be re-granted for the same request. It drops or changes `req`/`addr` after the edge that ends its `gnt` cycle.
- `burst_cnt` (4 bits):
  - Increments on each consecutive grant to the same port.
  - Clears to 0 when ownership changes or when passing through IDLE.
- In ACCx:
  - `mem_address = addrx`.
  - `mem_wdata = wdatax`.
  - `mem_we = wex`.
  - `gntx = 1`.
- In IDLE: `mem_address`, `mem_wdata` and `mem_we` are 0.
- Read capture: at the edge ending a read ACCx cycle, `rdata <= mem_rdata` and `rvalidx <= 1` for one cycle. `rdata` holds its value until the next read completes.
- Writes produce no `rvalid`.

## Timing
- Reset values: state IDLE; all `gnt`, `rvalid` and `mem_we` 0; `rdata`, `mem_address` and `mem_wdata` 0; `burst_cnt` 0; round-robin pointer prefers port 0.
- `gnt` and `mem_*` are decoded combinationally from the state register, so assertion of `resetn` drops `mem_we` immediately.
- An interrupted access is discarded. A pending `rvalid` is cleared.
- Latency:
  - `req` high in cycle N → `gnt` in cycle N+1 when uncontended.
  - Read data and `rvalid` in cycle N+2.
- Throughput: back-to-back ACC states are allowed, giving one access per cycle. An ownership switch costs no idle cycle.
- Simultaneous `req0`/`req1` in the same cycle: exactly one `gnt`. `gnt0 & gnt1` is never 1.
- Worst-case wait for a requesting port: `MAX_BURST` cycles.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: contention is resolved round-robin. The port not granted most recently wins, and the pointer updates on every grant.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, port 0 (core) always wins contention. The `MAX_BURST` bound still forces a grant to port 1 after `MAX_BURST` consecutive port-0 grants while `req1` is high.

## Test plan
- Reset:
  - Stimulus: hold `resetn=0`, drive random `req`s.
  - Required: all outputs 0, no `gnt`.
  - Stimulus: release `resetn`; `req0=1`, `we0=0`, `addr0=0x000` with memory word 0x00500093.
  - Required: `gnt0` in the next cycle; `rvalid0=1` with `rdata=0x00500093` one cycle later.
- Write then read:
  - Stimulus: port 1 writes 0xDEADBEEF to 0x800, then reads 0x800.
  - Required: `mem_we=1` only in the write's `gnt1` cycle; the read returns 0xDEADBEEF.
- Contention:
  - Stimulus: `req0` and `req1` held continuously, both reads, no lock.
  - Required with round-robin: grants alternate 0,1,0,1.
  - Required without round-robin: port 1 receives a grant only every `MAX_BURST+1` cycles.
- Locked burst:
  - Stimulus: `lock0=1` and `req0=1` for 8 cycles with `req1=1`, `MAX_BURST=4`.
  - Required: exactly 4 consecutive `gnt0`, then one `gnt1`, then port 0 resumes.
- Reset mid-write:
  - Stimulus: assert `resetn=0` during an ACC1 write cycle.
  - Required: `mem_we` falls without waiting for a clock edge; no `rvalid`; state IDLE after release.
- Idle gap:
  - Stimulus: single `req1` read at cycle 10, nothing after.
  - Required: state returns to IDLE at cycle 12; `burst_cnt=0`; `rdata` retains the read value.
